// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: multiply/divide ops, MD FSM states,
// ALU control codes and forwarding-mux selects.
package exec_pkg;

    typedef enum logic [1:0] {
        MD_MUL_LO = 2'b00,
        MD_MUL_HI = 2'b01,
        MD_DIV_Q  = 2'b10,
        MD_DIV_R  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    // Forwarding select: bit 1 set picks the EX/MEM result regardless of bit 0.
    localparam logic [1:0] FWD_ID = 2'b00;
    localparam logic [1:0] FWD_WB = 2'b01;
    localparam logic [1:0] FWD_EX = 2'b10;

endpackage

// File: rtl/exec_mdu.sv
// Iterative unsigned multiply (shift-add) and, with EXEC_MDU_DIV_EN defined,
// restoring divide. One iteration per cycle, DATA_W iterations per operation.
module exec_mdu
    import exec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  md_op_e            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] hi, lo, opb;
    logic [DATA_W-1:0] hi_nxt, lo_nxt;
    logic [DATA_W:0]   mul_sum;
    logic              hi_sel;
`ifdef EXEC_MDU_DIV_EN
    logic              div_r;
    logic [DATA_W:0]   div_trial;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = MD_DONE;
            end
            MD_DONE: begin
                done      = 1'b1;
                state_nxt = MD_IDLE;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // {hi,lo} is the product accumulator for multiply and {remainder,quotient}
    // for divide, so low-half ops read lo and high-half/remainder ops read hi.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        hi_nxt  = mul_sum[DATA_W:1];
        lo_nxt  = {mul_sum[0], lo[DATA_W-1:1]};
`ifdef EXEC_MDU_DIV_EN
        div_trial = {hi, lo[DATA_W-1]} - {1'b0, opb};
        if (div_r) begin
            if (!div_trial[DATA_W]) begin
                hi_nxt = div_trial[DATA_W-1:0];
                lo_nxt = {lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_nxt = {hi[DATA_W-2:0], lo[DATA_W-1]};
                lo_nxt = {lo[DATA_W-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            opb    <= '0;
            hi_sel <= 1'b0;
`ifdef EXEC_MDU_DIV_EN
            div_r  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                MD_IDLE: if (start) begin
                    hi     <= '0;
                    lo     <= a;
                    opb    <= b;
                    hi_sel <= (op == MD_MUL_HI) || (op == MD_DIV_R);
`ifdef EXEC_MDU_DIV_EN
                    div_r  <= (op == MD_DIV_Q) || (op == MD_DIV_R);
`endif
                    cnt    <= CNT_W'(DATA_W);
                end
                MD_BUSY: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign result = hi_sel ? hi : lo;

endmodule

// File: rtl/exec_stage_mdu.sv
// Execute stage: forwarding muxes, ALU, link path, iterative MD unit and the
// EX/MEM register. Divide support is built only when EXEC_MDU_DIV_EN is defined.
module exec_stage_mdu
    import exec_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_OFFSET = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_id,
    input  logic [DATA_W-1:0]         reg_a_id_r,
    input  logic [DATA_W-1:0]         reg_b_id_r,
    input  logic [DATA_W-1:0]         imm_ext_id_r,
    input  logic [DATA_W-1:0]         pc_plus_1_id_r,
    input  logic [REG_AW-1:0]         reg_wr_addr_id_r,
    input  logic [$clog2(DATA_W)-1:0] sa_id_r,
    input  logic [DATA_W-1:0]         reg_wr_data_wb,
    input  logic [1:0]                src_a_mux,
    input  logic [1:0]                src_b_mux,
    input  logic                      jal_sel_ex,
    input  logic                      alu_a_mux_sel_ex,
    input  logic                      alu_b_mux_sel_ex,
    input  logic [3:0]                alu_ctrl_ex,
    input  logic                      md_start_ex,
    input  logic [1:0]                md_op_ex,
    output logic                      stall_ex,
    output logic                      alu_zero_ex,
    output logic [REG_AW-1:0]         reg_wr_addr_ex,
    output logic [DATA_W-1:0]         exec_out_fw,
    output logic [DATA_W-1:0]         exec_out_ex_r,
    output logic [DATA_W-1:0]         reg_b_ex_r,
    output logic [REG_AW-1:0]         reg_wr_addr_ex_r,
    output logic                      valid_ex_r
);

    localparam int SA_W = $clog2(DATA_W);

    logic [DATA_W-1:0] src_a, src_b, alu_a, alu_b, alu_res, ex_result, md_result;
    logic [SA_W-1:0]   shamt;
    logic              md_req, md_go, md_busy, md_done, md_idle;

    function automatic logic [DATA_W-1:0] fwd_pick(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] ex,
                                                  input logic [DATA_W-1:0] wb,
                                                  input logic [DATA_W-1:0] id);
        if (sel[1])            return ex;
        else if (sel == FWD_WB) return wb;
        else                   return id;
    endfunction

    assign exec_out_fw = exec_out_ex_r;
    assign src_a = fwd_pick(src_a_mux, exec_out_fw, reg_wr_data_wb, reg_a_id_r);
    assign src_b = fwd_pick(src_b_mux, exec_out_fw, reg_wr_data_wb, reg_b_id_r);
    assign alu_a = alu_a_mux_sel_ex ? {{(DATA_W-SA_W){1'b0}}, sa_id_r} : src_a;
    assign alu_b = alu_b_mux_sel_ex ? imm_ext_id_r : src_b;
    assign shamt = alu_a[SA_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_ctrl_ex)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_NOR:  alu_res = ~(alu_a | alu_b);
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, alu_a < alu_b};
            ALU_SLL:  alu_res = alu_b << shamt;
            ALU_SRL:  alu_res = alu_b >> shamt;
            ALU_SRA:  alu_res = $signed(alu_b) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    assign alu_zero_ex    = (alu_res == '0);
    assign reg_wr_addr_ex = reg_wr_addr_id_r | {REG_AW{jal_sel_ex}};

    // Without the divider, divide ops fall through the single-cycle path as zero.
    assign md_req  = valid_id & md_start_ex;
    assign md_idle = ~md_busy & ~md_done;
`ifdef EXEC_MDU_DIV_EN
    assign md_go   = md_req & md_idle;
`else
    assign md_go   = md_req & md_idle & ~md_op_ex[1];
`endif
    assign stall_ex = ~rst & (md_go | md_busy);

    assign ex_result = jal_sel_ex ? (pc_plus_1_id_r + DATA_W'(LINK_OFFSET))
                     : md_req     ? '0
                     :              alu_res;

    exec_mdu #(.DATA_W(DATA_W)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (md_go),
        .op     (md_op_e'(md_op_ex)),
        .a      (src_a),
        .b      (src_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_out_ex_r    <= '0;
            reg_b_ex_r       <= '0;
            reg_wr_addr_ex_r <= '0;
            valid_ex_r       <= 1'b0;
        end else if (stall_ex || !valid_id) begin
            reg_wr_addr_ex_r <= '0;
            valid_ex_r       <= 1'b0;
        end else begin
            exec_out_ex_r    <= md_done ? md_result : ex_result;
            reg_b_ex_r       <= src_b;
            reg_wr_addr_ex_r <= reg_wr_addr_ex;
            valid_ex_r       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exec_stage_mdu.sv
// Randomized and directed bench for exec_stage_mdu against an arithmetic
// reference model; follows EXEC_MDU_DIV_EN when it is defined for the build.
module tb_exec_stage_mdu;
    import exec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
`ifdef EXEC_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_id = 1'b0;
    logic [DW-1:0] reg_a_id_r = '0, reg_b_id_r = '0, imm_ext_id_r = '0, pc_plus_1_id_r = '0;
    logic [AW-1:0] reg_wr_addr_id_r = '0;
    logic [4:0]    sa_id_r = '0;
    logic [DW-1:0] reg_wr_data_wb = '0;
    logic [1:0]    src_a_mux = '0, src_b_mux = '0;
    logic          jal_sel_ex = 1'b0, alu_a_mux_sel_ex = 1'b0, alu_b_mux_sel_ex = 1'b0;
    logic [3:0]    alu_ctrl_ex = '0;
    logic          md_start_ex = 1'b0;
    logic [1:0]    md_op_ex = '0;
    logic          stall_ex, alu_zero_ex, valid_ex_r;
    logic [AW-1:0] reg_wr_addr_ex, reg_wr_addr_ex_r;
    logic [DW-1:0] exec_out_fw, exec_out_ex_r, reg_b_ex_r;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] m_out = '0, m_b = '0;
    logic [AW-1:0] m_addr = '0;
    logic          m_valid = 1'b0;

    always #5 clk = ~clk;

    exec_stage_mdu dut (
        .clk(clk), .rst(rst), .valid_id(valid_id),
        .reg_a_id_r(reg_a_id_r), .reg_b_id_r(reg_b_id_r), .imm_ext_id_r(imm_ext_id_r),
        .pc_plus_1_id_r(pc_plus_1_id_r), .reg_wr_addr_id_r(reg_wr_addr_id_r), .sa_id_r(sa_id_r),
        .reg_wr_data_wb(reg_wr_data_wb), .src_a_mux(src_a_mux), .src_b_mux(src_b_mux),
        .jal_sel_ex(jal_sel_ex), .alu_a_mux_sel_ex(alu_a_mux_sel_ex), .alu_b_mux_sel_ex(alu_b_mux_sel_ex),
        .alu_ctrl_ex(alu_ctrl_ex), .md_start_ex(md_start_ex), .md_op_ex(md_op_ex),
        .stall_ex(stall_ex), .alu_zero_ex(alu_zero_ex), .reg_wr_addr_ex(reg_wr_addr_ex),
        .exec_out_fw(exec_out_fw), .exec_out_ex_r(exec_out_ex_r), .reg_b_ex_r(reg_b_ex_r),
        .reg_wr_addr_ex_r(reg_wr_addr_ex_r), .valid_ex_r(valid_ex_r)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int sh;
        sh = int'(a % 32);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_SLTU: return (a < b) ? 1 : 0;
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA:  return $signed(b) >>> sh;
            default:  return '0;
        endcase
    endfunction

    // Presents one ID/EX instruction, follows any stall and checks the EX/MEM result.
    task automatic issue(input logic v, input logic md, input logic jal, input logic [1:0] mop,
                         input logic [1:0] sam, input logic [1:0] sbm, input logic asel, input logic bsel,
                         input logic [3:0] ctrl, input logic [DW-1:0] ra, input logic [DW-1:0] rb,
                         input logic [DW-1:0] imm, input logic [DW-1:0] pc, input logic [DW-1:0] wb,
                         input logic [AW-1:0] wa, input logic [4:0] sa);
        logic [DW-1:0] va, vb, aa, bb, res;
        logic [63:0]   prod;
        logic [AW-1:0] waddr;
        bit            is_md, stalls;
        int            n;
        valid_id = v; md_start_ex = md; jal_sel_ex = jal; md_op_ex = mop;
        src_a_mux = sam; src_b_mux = sbm; alu_a_mux_sel_ex = asel; alu_b_mux_sel_ex = bsel;
        alu_ctrl_ex = ctrl; reg_a_id_r = ra; reg_b_id_r = rb; imm_ext_id_r = imm;
        pc_plus_1_id_r = pc; reg_wr_data_wb = wb; reg_wr_addr_id_r = wa; sa_id_r = sa;
        #1;
        va = sam[1] ? m_out : (sam[0] ? wb : ra);
        vb = sbm[1] ? m_out : (sbm[0] ? wb : rb);
        aa = asel ? DW'(sa) : va;
        bb = bsel ? imm : vb;
        waddr = jal ? 5'd31 : wa;
        prod = 64'(va) * 64'(vb);
        is_md = v && md;
        stalls = is_md && (DIV_EN || !mop[1]);
        if (jal) res = pc;
        else if (is_md) begin
            case (mop)
                2'b00:   res = prod[31:0];
                2'b01:   res = prod[63:32];
                2'b10:   res = !DIV_EN ? '0 : (vb == 0) ? '1 : va / vb;
                default: res = !DIV_EN ? '0 : (vb == 0) ? va : va % vb;
            endcase
        end else res = alu_ref(ctrl, aa, bb);
        check("stall", stall_ex, stalls);
        check("wr_addr_ex", reg_wr_addr_ex, waddr);
        if (!jal && !is_md) check("alu_zero", alu_zero_ex, res == 0);
        if (stalls) begin
            n = 0;
            while (stall_ex && n < 100) begin
                n++;
                @(posedge clk); #1;
                if (stall_ex) begin
                    check("bubble_valid", valid_ex_r, 0);
                    check("bubble_addr", reg_wr_addr_ex_r, 0);
                    check("bubble_hold", exec_out_ex_r, m_out);
                end
            end
            check("stall_cycles", n, DW + 1);
        end
        @(posedge clk); #1;
        if (v) begin
            m_out = res; m_b = vb; m_addr = waddr; m_valid = 1'b1;
        end else begin
            m_addr = '0; m_valid = 1'b0;
        end
        check("exec_out", exec_out_ex_r, m_out);
        check("exec_out_fw", exec_out_fw, m_out);
        check("reg_b", reg_b_ex_r, m_b);
        check("wr_addr_r", reg_wr_addr_ex_r, m_addr);
        check("valid", valid_ex_r, m_valid);
    endtask

    task automatic bubble();
        issue(0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD, 1, 2, 3, 4, 5, 5'd3, 5'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb;
        int kind;
        // Reset with an MD request pending: no stall, EX/MEM cleared
        valid_id = 1; md_start_ex = 1; md_op_ex = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", stall_ex, 0);
        check("rst_out", exec_out_ex_r, 0);
        check("rst_b", reg_b_ex_r, 0);
        check("rst_addr", reg_wr_addr_ex_r, 0);
        check("rst_valid", valid_ex_r, 0);
        rst = 0; valid_id = 0; md_start_ex = 0;
        bubble();

        // ADD forwarding from EX/MEM
        issue(1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD, 2, 3, 0, 0, 0, 5'd4, 5'd0);
        issue(1, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0, ALU_ADD, 99, 7, 0, 0, 0, 5'd4, 5'd0);
        check("add_fwd_12", exec_out_ex_r, 12);
        // MUL high: 2^16 * 2^16
        issue(1, 1, 0, 2'b01, 2'b00, 2'b00, 0, 0, ALU_ADD, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 5'd6, 5'd0);
        check("mulh_one", exec_out_ex_r, 1);
        bubble();
        // Divide / remainder, including divide by zero
        issue(1, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0, ALU_ADD, 100, 7, 0, 0, 0, 5'd7, 5'd0);
        issue(1, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, ALU_ADD, 100, 7, 0, 0, 0, 5'd7, 5'd0);
        issue(1, 1, 0, 2'b10, 2'b00, 2'b00, 0, 0, ALU_ADD, 9, 0, 0, 0, 0, 5'd7, 5'd0);
        issue(1, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0, ALU_ADD, 9, 0, 0, 0, 0, 5'd7, 5'd0);
        // JAL link
        issue(1, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD, 1, 1, 0, 32'h40, 0, 5'd0, 5'd0);
        check("jal_addr_31", reg_wr_addr_ex_r, 31);

        // Reset during the 10th BUSY cycle aborts the multiply
        valid_id = 1; md_start_ex = 1; md_op_ex = 2'b00; jal_sel_ex = 0;
        src_a_mux = 2'b00; src_b_mux = 2'b00; reg_a_id_r = 123; reg_b_id_r = 456;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        check("busy10_stall", stall_ex, 1);
        rst = 1;
        @(posedge clk); #1;
        check("rst_busy_stall", stall_ex, 0);
        rst = 0; valid_id = 0; md_start_ex = 0;
        #1;
        check("abort_stall", stall_ex, 0);
        check("abort_out", exec_out_ex_r, 0);
        check("abort_b", reg_b_ex_r, 0);
        check("abort_addr", reg_wr_addr_ex_r, 0);
        check("abort_valid", valid_ex_r, 0);
        m_out = '0; m_b = '0; m_addr = '0; m_valid = 1'b0;
        issue(1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, ALU_ADD, 1000, 1000, 0, 0, 0, 5'd9, 5'd0);
        check("mul_after_abort", exec_out_ex_r, 1_000_000);

        // Random instruction mix
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if (kind == 9) bubble();
            else if (kind == 8)
                issue(1, 0, 1, 2'b00, 2'($urandom), 2'($urandom), 0, 0, ALU_ADD, ra, rb, 0,
                      $urandom, $urandom, 5'($urandom), 5'($urandom));
            else if (kind >= 6) begin
                if ($urandom_range(0, 3) == 0) rb = 0;
                else if ($urandom_range(0, 1) == 0) rb = $urandom_range(1, 1000);
                issue(1, 1, 0, 2'($urandom), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                      2'b00, 0, 0, ALU_ADD, ra, rb, 0, 0, $urandom, 5'($urandom), 5'd0);
            end else
                issue(1, 0, 0, 2'b00, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom_range(0, 11)), ra, ($urandom_range(0, 4) == 0) ? ra : rb,
                      $urandom, 0, $urandom, 5'($urandom), 5'($urandom));
        end
        bubble();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_stage_mdu.md
EXEC_STAGE_MDU -- requirements
Module: exec_stage_mdu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width (power of two, 8..64).
REQ-002 SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 SHALL have parameter LINK_OFFSET, default 0, constant added to pc_plus_1_id_r for link results.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-005 valid_id in 1: ID/EX register holds a live instruction.
REQ-006 reg_a_id_r, reg_b_id_r, imm_ext_id_r, pc_plus_1_id_r in DATA_W: operands, immediate and next-PC from ID.
REQ-007 reg_wr_addr_id_r in REG_AW; sa_id_r in log2(DATA_W): destination register and shift amount.
REQ-008 reg_wr_data_wb in DATA_W: WB-stage forwarding source.
REQ-009 src_a_mux, src_b_mux in 2: 1? = exec_out_fw, 01 = reg_wr_data_wb, 00 = ID operand.
REQ-010 jal_sel_ex, alu_a_mux_sel_ex, alu_b_mux_sel_ex in 1; alu_ctrl_ex in 4: ALU control.
REQ-011 md_start_ex in 1; md_op_ex in 2: 00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder (all unsigned).
REQ-012 stall_ex out 1: hold PC, IF/ID and ID/EX.
REQ-013 alu_zero_ex out 1; reg_wr_addr_ex out REG_AW; exec_out_fw out DATA_W.
REQ-014 exec_out_ex_r, reg_b_ex_r out DATA_W; reg_wr_addr_ex_r out REG_AW; valid_ex_r out 1: EX/MEM register.

Function
REQ-015 Forwarding muxes SHALL select src_a/src_b per REQ-009; alu_a = alu_a_mux_sel_ex ? zero-extended sa_id_r : src_a; alu_b = alu_b_mux_sel_ex ? imm_ext_id_r : src_b.
REQ-016 Non-MD instruction SHALL register its result with 1-cycle latency: jal_sel_ex ? pc_plus_1_id_r + LINK_OFFSET (mod 2^DATA_W) : ALU result.
REQ-017 reg_wr_addr_ex SHALL equal reg_wr_addr_id_r OR {REG_AW{jal_sel_ex}}.
REQ-018 exec_out_fw SHALL equal exec_out_ex_r.
REQ-019 MD FSM SHALL have states IDLE, BUSY, DONE.
REQ-020 IDLE with valid_id & md_start_ex: latch src_a, src_b, md_op_ex; counter = DATA_W; go to BUSY; stall_ex=1 combinationally in that cycle.
REQ-021 BUSY: one shift-add/restoring-divide iteration per cycle; stall_ex=1; counter decrements; at counter=1 go to DONE.
REQ-022 DONE: stall_ex=0; EX/MEM loads MD result with valid_ex_r=1; next state IDLE; new MD start is accepted only from IDLE.
REQ-023 Total stall SHALL be DATA_W+1 cycles; result is visible in exec_out_ex_r DATA_W+2 edges after the start cycle's edge.
REQ-024 While stall_ex=1, EX/MEM SHALL load a bubble: valid_ex_r=0, reg_wr_addr_ex_r=0, exec_out_ex_r and reg_b_ex_r hold.
REQ-025 Divide by zero: quotient = all ones, remainder = dividend; same latency.
REQ-026 valid_id=0 SHALL register a bubble (valid_ex_r=0, reg_wr_addr_ex_r=0) and never start the MD unit.

Reset
REQ-027 rst SHALL clear exec_out_ex_r, reg_b_ex_r, reg_wr_addr_ex_r, valid_ex_r to 0, force FSM to IDLE and counter to 0.
REQ-028 stall_ex SHALL be 0 while rst=1; reset mid-BUSY SHALL abort the operation, discarding its result.

Configuration
REQ-029 Macro EXEC_MDU_DIV_EN: defined -> divide ops per REQ-020..025; undefined -> md_op_ex 1x produces 0 with 1-cycle latency, no stall, no divider logic.

Structure
REQ-030 Package exec_pkg SHALL hold md_op encodings, FSM state encodings, ALU control codes and forwarding-mux codes.
REQ-031 Iterative multiply/divide SHALL be sub-module exec_mdu (start/op/operands in, busy/done/result out); ALU SHALL be parametrised to DATA_W.

Verification (DATA_W=32, LINK_OFFSET=0)
REQ-032 ADD, src_a_mux=10 with exec_out_ex_r=5, reg_b_id_r=7 -> exec_out_ex_r=12 next edge, stall_ex=0.
REQ-033 MUL high, 0x0001_0000 x 0x0001_0000 -> stall_ex high 33 cycles, then exec_out_ex_r=0x1, valid_ex_r=1 for one cycle.
REQ-034 DIV 100/7 -> 14; REM 100/7 -> 2; DIV 9/0 -> 0xFFFF_FFFF; REM 9/0 -> 9.
REQ-035 rst at 10th BUSY cycle -> next cycle stall_ex=0, all EX/MEM outputs 0; next MD start completes normally.
REQ-036 jal_sel_ex=1, pc_plus_1_id_r=0x40, reg_wr_addr_id_r=0 -> reg_wr_addr_ex_r=31, exec_out_ex_r=0x40.
REQ-037 EXEC_MDU_DIV_EN undefined, DIV 100/7 -> exec_out_ex_r=0 after 1 cycle, stall_ex never 1.
